// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
//  - Access size encodings as they arrive from EX/MEM (size_in).
//  - FSM state encodings for mem_access_unit.
//  - is_misaligned(): alignment rule shared by the controller.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  // 2'b11 is reserved and handled as a word everywhere.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Half needs addr[0]=0; word (and reserved) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_HALF) begin
      mis = addr_lo[0];
    end else if (size[1]) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
//  mem_req   master->slave  request, held until ack
//  mem_we    master->slave  1 = write
//  mem_addr  master->slave  word-aligned byte address
//  mem_wdata master->slave  lane-replicated store data
//  mem_be    master->slave  byte enables, little-endian
//  mem_ack   slave->master  access done; mem_rdata valid in the same cycle
//  mem_rdata slave->master  read word
interface mem_access_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data aligner: selects the addressed byte/half of a read word
// and sign- or zero-extends it to 32 bits. Words (and reserved size) pass through.
//  i_rdata    in  32  word returned by the data memory
//  i_addr_lo  in  2   low address bits of the load
//  i_size     in  2   access size encoding
//  i_unsigned in  1   1 = zero-extend, 0 = sign-extend
//  o_data     out 32  aligned, extended load data
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    unique case (i_size)
      SIZE_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller. Converts EX/MEM load/store control into a
// req/ack transaction, stalls the pipeline until the memory answers (or the
// watchdog fires), and presents aligned/extended load data to MEM/WB.
//  clk, reset         clock (rising edge), asynchronous active-high reset
//  addr_in, wdata_in  byte address and store data from EX/MEM
//  mem_read_in/_write_in, size_in, unsigned_in   access control from EX/MEM
//  bus                data-memory master port (mem_access_unit_if.master)
//  read_data          load data for MEM/WB ReadData
//  stall              freeze upstream stages; MEM/WB must not capture
//  misalign_err       1-cycle pulse, misaligned access dropped
//  bus_err            1-cycle pulse, watchdog expired
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  mem_access_unit_if.master bus,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] CntLast = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_req, w_req_nxt;
  logic             r_we, w_we_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic [3:0]       r_be, w_be_nxt;
  logic [1:0]       r_size, w_size_nxt;
  logic [1:0]       r_addr_lo, w_addr_lo_nxt;
  logic             r_unsigned, w_unsigned_nxt;
  logic [31:0]      r_read_data, w_read_data_nxt;
  logic             r_misalign, w_misalign_nxt;
  logic             r_bus_err, w_bus_err_nxt;

  logic             w_access;
  logic             w_misaligned;
  logic             w_timeout;
  logic [3:0]       w_be_st;
  logic [31:0]      w_wdata_st;
  logic [31:0]      w_load_data;
  logic             w_stall;

  assign w_access     = mem_read_in | mem_write_in;
  assign w_misaligned = is_misaligned(size_in, addr_in[1:0]);
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CntLast);

  // Store lane placement; loads always enable all four bytes.
  always_comb begin
    w_be_st    = 4'b1111;
    w_wdata_st = wdata_in;
    unique case (size_in)
      SIZE_BYTE: begin
        w_be_st    = 4'b0001 << addr_in[1:0];
        w_wdata_st = {4{wdata_in[7:0]}};
      end
      SIZE_HALF: begin
        w_be_st    = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata_st = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the captured size/lane so it is independent of the frozen inputs.
  mem_load_align u_load_align (
    .i_rdata    (bus.mem_rdata),
    .i_addr_lo  (r_addr_lo),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_nxt       = r_req;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_be_nxt        = r_be;
    w_size_nxt      = r_size;
    w_addr_lo_nxt   = r_addr_lo;
    w_unsigned_nxt  = r_unsigned;
    w_read_data_nxt = r_read_data;
    w_misalign_nxt  = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_stall         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_misalign_nxt  = 1'b1;
            w_read_data_nxt = '0;
          end else begin
            w_stall        = 1'b1;
            w_req_nxt      = 1'b1;
            w_we_nxt       = mem_write_in;
            w_addr_nxt     = {addr_in[31:2], 2'b00};
            w_wdata_nxt    = w_wdata_st;
            w_be_nxt       = mem_write_in ? w_be_st : 4'b1111;
            w_size_nxt     = size_in;
            w_addr_lo_nxt  = addr_in[1:0];
            w_unsigned_nxt = unsigned_in;
            w_cnt_nxt      = '0;
            w_state_nxt    = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        // Ack takes priority over a watchdog expiry in the same cycle.
        if (bus.mem_ack) begin
          w_req_nxt = 1'b0;
          if (!r_we) begin
            w_read_data_nxt = w_load_data;
          end
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_req_nxt       = 1'b0;
          w_read_data_nxt = '0;
          w_bus_err_nxt   = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        // The completed instruction is still at the inputs; do not restart it.
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (reset) begin
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_size      <= '0;
      r_addr_lo   <= '0;
      r_unsigned  <= 1'b0;
      r_read_data <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req       <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_be        <= w_be_nxt;
      r_size      <= w_size_nxt;
      r_addr_lo   <= w_addr_lo_nxt;
      r_unsigned  <= w_unsigned_nxt;
      r_read_data <= w_read_data_nxt;
      r_misalign  <= w_misalign_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign read_data     = r_read_data;
  assign stall         = w_stall;
  assign misalign_err  = r_misalign;
  assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign_err;
  logic        bus_err;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .TIMEOUT (TO),
    .CNT_W   (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .size_in      (size_in),
    .unsigned_in  (unsigned_in),
    .bus          (bus),
    .read_data    (read_data),
    .stall        (stall),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned wait_n;   // BUSY cycles without ack before the ack cycle
    logic [31:0] rdata;
    logic [31:0] exp_rd;   // loads only
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata; // stores only
    logic        exp_mis;
    logic        exp_to;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on byte counts.
  function automatic int unsigned ref_nbytes(input logic [1:0] sz);
    int unsigned nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return nb;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    return (addr % ref_nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] sz, input logic uns);
    int unsigned nb;
    logic [31:0] v;
    logic [31:0] lim;
    nb = ref_nbytes(sz);
    if (nb == 4) return rdata;
    v   = rdata >> (8 * (addr % 4));
    lim = 32'd1 << (8 * nb);
    v   = v % lim;
    if (!uns && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] addr);
    int unsigned nb;
    logic [31:0] b;
    nb = ref_nbytes(sz);
    b  = (nb == 4) ? 32'd15 : (((32'd1 << nb) - 1) << (addr % 4));
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wdata);
    int unsigned nb;
    nb = ref_nbytes(sz);
    if (nb == 1) return (wdata % 256) * 32'h0101_0101;
    if (nb == 2) return (wdata % 65536) * 32'h0001_0001;
    return wdata;
  endfunction

  task automatic set_idle_inputs();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  // Runs one MEM-stage instruction from its first IDLE cycle through DONE,
  // acting as both the pipeline (inputs held while stalled) and the memory.
  task automatic run_access(input vec_t v, input string nm);
    int unsigned busy;
    logic        done;
    logic [31:0] exp_read;
    tick();
    mem_read_in  = v.rd;
    mem_write_in = v.wr;
    size_in      = v.sz;
    unsigned_in  = v.uns;
    addr_in      = v.addr;
    wdata_in     = v.wdata;
    bus.mem_ack  = 1'b0;
    bus.mem_rdata = $urandom;
    #1;
    check({nm, " err_pulses_clear"}, {bus_err, misalign_err}, 2'b00);
    if (v.exp_mis) begin
      check({nm, " mis_stall"}, stall, 1'b0);
      check({nm, " mis_req"}, bus.mem_req, 1'b0);
      tick();
      set_idle_inputs();
      #1;
      check({nm, " mis_pulse"}, misalign_err, 1'b1);
      check({nm, " mis_rdata"}, read_data, 32'h0);
      check({nm, " mis_no_req"}, bus.mem_req, 1'b0);
      last_rd = 32'h0;
      return;
    end
    check({nm, " idle_stall"}, stall, 1'b1);
    check({nm, " idle_no_req_yet"}, bus.mem_req, 1'b0);
    busy = 0;
    done = 1'b0;
    while (!done) begin
      tick();
      busy++;
      bus.mem_ack   = (busy - 1 == v.wait_n);
      bus.mem_rdata = bus.mem_ack ? v.rdata : $urandom;
      #1;
      check({nm, " busy_req"}, bus.mem_req, 1'b1);
      check({nm, " busy_stall"}, stall, 1'b1);
      check({nm, " busy_addr"}, bus.mem_addr, v.addr & ~32'd3);
      check({nm, " busy_we"}, bus.mem_we, v.wr);
      check({nm, " busy_be"}, bus.mem_be, v.exp_be);
      if (v.wr) check({nm, " busy_wdata"}, bus.mem_wdata, v.exp_wdata);
      if (bus.mem_ack || busy == TO) done = 1'b1;
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    exp_read = v.exp_to ? 32'h0 : (v.rd ? v.exp_rd : last_rd);
    check({nm, " done_stall"}, stall, 1'b0);
    check({nm, " done_req"}, bus.mem_req, 1'b0);
    check({nm, " done_bus_err"}, bus_err, v.exp_to);
    check({nm, " done_read_data"}, read_data, exp_read);
    last_rd = exp_read;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // rd wr sz uns addr wdata wait rdata | exp_rd be wdata mis to
    tbl[0]  = '{1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0};
    tbl[1]  = '{1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h80FF0000, 32'hFFFFFF80, 4'hF, 32'h0, 0, 0};
    tbl[2]  = '{1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 32'h80FF0000, 32'h00000080, 4'hF, 32'h0, 0, 0};
    tbl[3]  = '{1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 32'h80FF0000, 32'hFFFF80FF, 4'hF, 32'h0, 0, 0};
    tbl[4]  = '{0, 1, 2'd0, 0, 32'h101, 32'hAB, 1, 32'h0, 32'h0, 4'b0010, 32'hABABABAB, 0, 0};
    tbl[5]  = '{0, 1, 2'd2, 0, 32'h102, 32'h55, 0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 0};
    tbl[6]  = '{0, 1, 2'd1, 0, 32'h106, 32'h1234CDEF, 2, 32'h0, 32'h0, 4'b1100, 32'hCDEFCDEF,
                0, 0};
    tbl[7]  = '{1, 0, 2'd1, 1, 32'h200, 32'h0, 3, 32'h1234F00D, 32'h0000F00D, 4'hF, 32'h0, 0, 0};
    tbl[8]  = '{1, 0, 2'd2, 0, 32'h300, 32'h0, 9, 32'h11111111, 32'h0, 4'hF, 32'h0, 0, 1};
    tbl[9]  = '{1, 0, 2'd1, 0, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 0};
    tbl[10] = '{1, 0, 2'd3, 0, 32'h010, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0};
    tbl[11] = '{1, 0, 2'd0, 0, 32'h000, 32'h0, 0, 32'h0000007F, 32'h0000007F, 4'hF, 32'h0, 0, 0};

    // Reset state, with an aligned access presented: stall must stay low.
    reset         = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    mem_read_in   = 1'b1;
    mem_write_in  = 1'b0;
    size_in       = 2'd2;
    unsigned_in   = 1'b0;
    addr_in       = 32'h40;
    wdata_in      = 32'h0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_be", bus.mem_be, 4'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_errs", {bus_err, misalign_err}, 2'b00);
    set_idle_inputs();
    tick();
    tick();
    reset   = 1'b0;
    last_rd = 32'h0;

    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while BUSY: request and stall drop at once; a late ack is ignored.
    tick();
    mem_read_in = 1'b1;
    size_in     = 2'd2;
    addr_in     = 32'h40;
    #1;
    check("rb_idle_stall", stall, 1'b1);
    tick();
    tick();
    #1;
    check("rb_busy_req", bus.mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rb_req_drop", bus.mem_req, 1'b0);
    check("rb_stall_drop", stall, 1'b0);
    check("rb_read_data", read_data, 32'h0);
    tick();
    set_idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    #1;
    check("rb_late_ack_stall", stall, 1'b0);
    check("rb_late_ack_req", bus.mem_req, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("rb_after_read_data", read_data, 32'h0);
    check("rb_after_req", bus.mem_req, 1'b0);
    check("rb_after_errs", {bus_err, misalign_err}, 2'b00);
    last_rd = 32'h0;

    // Randomized back-to-back accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.rd     = 1'($urandom_range(0, 1));
      v.wr     = ~v.rd;
      v.sz     = 2'($urandom_range(0, 3));
      v.uns    = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      if ($urandom_range(0, 2) != 0) v.addr = v.addr - (v.addr % ref_nbytes(v.sz));
      v.wdata  = $urandom;
      v.wait_n = $urandom_range(0, 5);
      v.rdata  = $urandom;
      v.exp_mis   = ref_misaligned(v.sz, v.addr);
      v.exp_to    = (v.wait_n >= TO);
      v.exp_rd    = ref_extract(v.rdata, v.addr, v.sz, v.uns);
      v.exp_be    = v.rd ? 4'hF : ref_be(v.sz, v.addr);
      v.exp_wdata = ref_wdata(v.sz, v.wdata);
      run_access(v, $sformatf("rnd%0d", i));
    end

    tick();
    set_idle_inputs();
    #1;
    tick();
    check("final_req", bus.mem_req, 1'b0);
    check("final_stall", stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
